// File: rtl/commit_aggregator_mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_mpu
// Description : Shared MPU types and constants for the commit-aggregation
//               path. It provides the issue-number type, the default table
//               sizes and the layout of one tracking-table entry.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_mpu;

    localparam int MPU_ISSUE_NO_W = 6;   // issue-number width
    localparam int NUM_COMMIT_SRC = 4;   // lanes, load/store, scalar, ...
    localparam int NUM_ENTRY_AGG  = 16;  // aggregator tracking-table depth

    typedef logic [MPU_ISSUE_NO_W-1:0] mpu_issue_no_t;

    // One tracking-table slot. Pend holds one bit per source that has not
    // acknowledged yet.
    typedef struct packed {
        logic                      Valid;
        mpu_issue_no_t             IssueNo;
        logic [NUM_COMMIT_SRC-1:0] Pend;
    } mpu_agg_entry_t;

endpackage : pkg_mpu
`default_nettype wire

// File: rtl/commit_aggregator_mpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. It searches upward from
//               I_Ptr, wrapping around, and grants the first requester it
//               finds. The pointer register lives in the parent.
// Ports       : I_Req      - request vector
//               I_Ptr      - highest-priority index this cycle
//               O_Grant    - one-hot grant
//               O_Grant_No - index of the granted requester
//               O_Valid    - some requester was granted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] I_Req,
    input  logic [PW-1:0]      I_Ptr,
    output logic [NUM_REQ-1:0] O_Grant,
    output logic [PW-1:0]      O_Grant_No,
    output logic               O_Valid
);

    logic [PW-1:0] w_cand;

    always_comb begin
        O_Grant    = '0;
        O_Grant_No = '0;
        O_Valid    = 1'b0;
        w_cand     = '0;
        // NUM_REQ is a power of two, so the PW-bit add wraps modulo NUM_REQ.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = I_Ptr + PW'(k);
            if (!O_Valid && I_Req[w_cand]) begin
                O_Valid    = 1'b1;
                O_Grant_No = w_cand;
            end
        end
        O_Grant[O_Grant_No] = O_Valid;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/commit_aggregator_mpu.sv
`default_nettype none
// ============================================================================
// Module      : commit_aggregator_mpu
// Description : Producer side of the MPU commit interface. It records each
//               dispatched issue and collects the per-source completion acks.
//               When an issue has no pending sources left, it emits one
//               single-cycle commit request carrying that issue number.
// Ports       : clock, reset (sync, active-low)
//               I_Req_Issue/I_Issue_No/I_Src_Mask - dispatch of a new issue
//               I_Ack/I_Ack_No                    - per-source completion
//               O_Req_Commit/O_CommitNo           - commit request
//               O_Full                            - table fully occupied
//               O_Err                             - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module commit_aggregator_mpu
    import pkg_mpu::*;
#(
    parameter int NUM_ENTRY      = NUM_ENTRY_AGG,
    parameter int NUM_SRC        = NUM_COMMIT_SRC,
    parameter int WIDTH_ISSUE_NO = MPU_ISSUE_NO_W
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              I_Req_Issue,
    input  logic [WIDTH_ISSUE_NO-1:0]         I_Issue_No,
    input  logic [NUM_SRC-1:0]                I_Src_Mask,
    input  logic [NUM_SRC-1:0]                I_Ack,
    input  logic [NUM_SRC*WIDTH_ISSUE_NO-1:0] I_Ack_No,
    output logic                              O_Req_Commit,
    output logic [WIDTH_ISSUE_NO-1:0]         O_CommitNo,
    output logic                              O_Full,
    output logic                              O_Err
);

    localparam int IDX_W = $clog2(NUM_ENTRY);
    localparam int CNT_W = IDX_W + 1;

    mpu_agg_entry_t [NUM_ENTRY-1:0] r_tab;
    mpu_agg_entry_t [NUM_ENTRY-1:0] w_tab_nxt;
    logic [CNT_W-1:0]               r_cnt;
    logic [IDX_W-1:0]               r_ptr;
    logic                           r_req_commit;
    mpu_issue_no_t                  r_commit_no;
    logic                           r_err;

    logic [NUM_ENTRY-1:0] w_ready;
    logic [NUM_ENTRY-1:0] w_grant;
    logic [IDX_W-1:0]     w_grant_no;
    logic                 w_gvalid;

    logic                 w_full;
    logic [IDX_W-1:0]     w_iss_idx;
    logic                 w_accept;
    logic                 w_iss_err;

    mpu_issue_no_t        w_ack_no  [NUM_SRC];
    logic [IDX_W-1:0]     w_ack_idx [NUM_SRC];
    logic [NUM_SRC-1:0]   w_ack_hit;
    logic                 w_ack_err;

    // ---------------------------------------------------------------- ready
    generate
        for (genvar j = 0; j < NUM_ENTRY; j++) begin : g_ready
            assign w_ready[j] = r_tab[j].Valid && (r_tab[j].Pend == '0);
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ    (NUM_ENTRY)
    ) u_arb (
        .I_Req      (w_ready),
        .I_Ptr      (r_ptr),
        .O_Grant    (w_grant),
        .O_Grant_No (w_grant_no),
        .O_Valid    (w_gvalid)
    );

    // ---------------------------------------------------------------- issue
    assign w_full    = (r_cnt == CNT_W'(NUM_ENTRY));
    assign w_iss_idx = I_Issue_No[IDX_W-1:0];
    // A slot that is being committed at this edge still counts as occupied.
    assign w_accept  = I_Req_Issue && !w_full && !r_tab[w_iss_idx].Valid;
    assign w_iss_err = I_Req_Issue && !w_accept;

    // ------------------------------------------------------------------ ack
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_ack
            assign w_ack_no[i]  = I_Ack_No[i*WIDTH_ISSUE_NO +: WIDTH_ISSUE_NO];
            assign w_ack_idx[i] = w_ack_no[i][IDX_W-1:0];
            // A full issue-number compare catches acks that alias onto a slot
            // now holding a different (wrapped) issue.
            assign w_ack_hit[i] = r_tab[w_ack_idx[i]].Valid &&
                                  (r_tab[w_ack_idx[i]].IssueNo == w_ack_no[i]);
        end
    endgenerate

    assign w_ack_err = |(I_Ack & ~w_ack_hit);

    // ------------------------------------------------------- table next-state
    // The grant only touches a valid entry and an accept only touches an
    // invalid one, so the two updates never target the same slot.
    always_comb begin
        w_tab_nxt = r_tab;
        for (int j = 0; j < NUM_ENTRY; j++) begin
            if (w_grant[j]) begin
                w_tab_nxt[j].Valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (I_Ack[i] && w_ack_hit[i]) begin
                w_tab_nxt[w_ack_idx[i]].Pend[i] = 1'b0;
            end
        end
        if (w_accept) begin
            w_tab_nxt[w_iss_idx].Valid   = 1'b1;
            w_tab_nxt[w_iss_idx].IssueNo = I_Issue_No;
            w_tab_nxt[w_iss_idx].Pend    = I_Src_Mask;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tab        <= '0;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_req_commit <= 1'b0;
            r_commit_no  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_tab <= w_tab_nxt;

            case ({w_accept, w_gvalid})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase

            r_req_commit <= w_gvalid;
            if (w_gvalid) begin
                r_commit_no <= r_tab[w_grant_no].IssueNo;
                r_ptr       <= w_grant_no + IDX_W'(1);
            end

            if (w_iss_err || w_ack_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign O_Req_Commit = r_req_commit;
    assign O_CommitNo   = r_commit_no;
    assign O_Full       = w_full;
    assign O_Err        = r_err;

endmodule : commit_aggregator_mpu
`default_nettype wire

// File: tb/tb_commit_aggregator_mpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_aggregator_mpu
// Description : Directed self-checking bench for commit_aggregator_mpu.
//               Inputs change 1 ns after a rising edge and outputs are
//               checked at the same point, so each check sees the state
//               registered by the preceding edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_aggregator_mpu;

    logic        clock;
    logic        reset;
    logic        I_Req_Issue;
    logic [5:0]  I_Issue_No;
    logic [3:0]  I_Src_Mask;
    logic [3:0]  I_Ack;
    logic [23:0] I_Ack_No;
    logic        O_Req_Commit;
    logic [5:0]  O_CommitNo;
    logic        O_Full;
    logic        O_Err;

    int n_cmp  = 0;
    int n_fail = 0;

    commit_aggregator_mpu dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req_Issue  (I_Req_Issue),
        .I_Issue_No   (I_Issue_No),
        .I_Src_Mask   (I_Src_Mask),
        .I_Ack        (I_Ack),
        .I_Ack_No     (I_Ack_No),
        .O_Req_Commit (O_Req_Commit),
        .O_CommitNo   (O_CommitNo),
        .O_Full       (O_Full),
        .O_Err        (O_Err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one issue for exactly one edge.
    task automatic issue(input logic [5:0] no, input logic [3:0] mask);
        I_Req_Issue = 1'b1;
        I_Issue_No  = no;
        I_Src_Mask  = mask;
        tick();
        I_Req_Issue = 1'b0;
        I_Issue_No  = '0;
        I_Src_Mask  = '0;
    endtask

    // Present one ack vector for exactly one edge. nN is source N's number.
    task automatic ack(input logic [3:0] m, input logic [5:0] n0, input logic [5:0] n1,
                       input logic [5:0] n2, input logic [5:0] n3);
        I_Ack    = m;
        I_Ack_No = {n3, n2, n1, n0};
        tick();
        I_Ack    = '0;
        I_Ack_No = '0;
    endtask

    initial begin
        reset       = 1'b0;
        I_Req_Issue = 1'b0;
        I_Issue_No  = '0;
        I_Src_Mask  = '0;
        I_Ack       = '0;
        I_Ack_No    = '0;

        // ---------------- reset
        tick();
        tick();
        chk("rst_req",  O_Req_Commit, 0);
        chk("rst_no",   O_CommitNo,   0);
        chk("rst_full", O_Full,       0);
        chk("rst_err",  O_Err,        0);
        reset = 1'b1;

        // ---------------- two-source issue 5; src0 re-acks with src1 (harmless)
        issue(6'd5, 4'b0011);
        ack(4'b0001, 6'd5, 6'd0, 6'd0, 6'd0);
        chk("t1_early", O_Req_Commit, 0);
        ack(4'b0011, 6'd5, 6'd5, 6'd0, 6'd0);
        chk("t1_ready_cycle", O_Req_Commit, 0);
        tick();
        chk("t1_req", O_Req_Commit, 1);
        chk("t1_no",  O_CommitNo,   5);
        tick();
        chk("t1_req_once", O_Req_Commit, 0);
        chk("t1_no_hold",  O_CommitNo,   5);
        chk("t1_err",      O_Err,        0);

        // ---------------- mask 0: commit two cycles after issue
        issue(6'd7, 4'b0000);
        chk("t2_req_early", O_Req_Commit, 0);
        tick();
        chk("t2_req", O_Req_Commit, 1);
        chk("t2_no",  O_CommitNo,   7);
        tick();
        chk("t2_req_once", O_Req_Commit, 0);
        chk("t2_empty",    O_Full,       0);

        // ---------------- fill the table
        for (int i = 0; i < 16; i++) begin
            issue(6'(i), 4'b0001);
        end
        chk("t3_full", O_Full, 1);
        chk("t3_err0", O_Err,  0);
        issue(6'd16, 4'b0001);
        chk("t3_rej_err",  O_Err,  1);
        chk("t3_rej_full", O_Full, 1);
        ack(4'b0001, 6'd3, 6'd0, 6'd0, 6'd0);
        chk("t3_ack_nocommit", O_Req_Commit, 0);
        tick();
        chk("t3_req",     O_Req_Commit, 1);
        chk("t3_no",      O_CommitNo,   3);
        chk("t3_notfull", O_Full,       0);
        issue(6'd19, 4'b0001);
        chk("t3_refill", O_Full, 1);

        // ---------------- round robin: 2, 9, 14 together, then 1 and 15
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t4_rst_full", O_Full, 0);
        chk("t4_rst_err",  O_Err,  0);
        issue(6'd2,  4'b0001);
        issue(6'd9,  4'b0010);
        issue(6'd14, 4'b0100);
        ack(4'b0111, 6'd2, 6'd9, 6'd14, 6'd0);
        chk("t4_none", O_Req_Commit, 0);
        tick();
        chk("t4_a_req", O_Req_Commit, 1);
        chk("t4_a_no",  O_CommitNo,   2);
        tick();
        chk("t4_b_req", O_Req_Commit, 1);
        chk("t4_b_no",  O_CommitNo,   9);
        tick();
        chk("t4_c_req", O_Req_Commit, 1);
        chk("t4_c_no",  O_CommitNo,   14);
        tick();
        chk("t4_idle", O_Req_Commit, 0);
        issue(6'd1,  4'b0001);
        issue(6'd15, 4'b0010);
        ack(4'b0011, 6'd1, 6'd15, 6'd0, 6'd0);
        tick();
        chk("t4_d_req", O_Req_Commit, 1);
        chk("t4_d_no",  O_CommitNo,   15);
        tick();
        chk("t4_e_req", O_Req_Commit, 1);
        chk("t4_e_no",  O_CommitNo,   1);
        tick();
        chk("t4_idle2", O_Req_Commit, 0);
        chk("t4_err",   O_Err,        0);

        // ---------------- four sources ack 8 together
        issue(6'd8, 4'b1111);
        ack(4'b1111, 6'd8, 6'd8, 6'd8, 6'd8);
        chk("t5_none", O_Req_Commit, 0);
        tick();
        chk("t5_req", O_Req_Commit, 1);
        chk("t5_no",  O_CommitNo,   8);
        tick();
        chk("t5_single", O_Req_Commit, 0);
        chk("t5_err0",   O_Err,        0);
        // aliasing ack: slot 8 holds issue 8, ack carries 40
        issue(6'd8, 4'b0001);
        ack(4'b0001, 6'd40, 6'd0, 6'd0, 6'd0);
        chk("t5_alias_err", O_Err, 1);
        tick();
        chk("t5_alias_ignored", O_Req_Commit, 0);
        ack(4'b0001, 6'd8, 6'd0, 6'd0, 6'd0);
        tick();
        chk("t5_clean_req", O_Req_Commit, 1);
        chk("t5_clean_no",  O_CommitNo,   8);

        // ---------------- reset mid-stream discards pending entries
        issue(6'd20, 4'b0001);
        issue(6'd21, 4'b0011);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_req",  O_Req_Commit, 0);
        chk("t6_full", O_Full,       0);
        chk("t6_err",  O_Err,        0);
        ack(4'b0001, 6'd20, 6'd0, 6'd0, 6'd0);
        tick();
        chk("t6_late_err", O_Err,        1);
        chk("t6_no_commit", O_Req_Commit, 0);
        tick();
        chk("t6_no_commit2", O_Req_Commit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_commit_aggregator_mpu
`default_nettype wire
